// File: rtl/tv_pkg.sv
// Shared types and helpers for the test-vector sequencer: FSM states, error-count width and
// field extraction for {inputs, expected} packed vector words.
package tv_pkg;

  localparam int unsigned ERR_W     = 16;
  localparam int unsigned SETTLE_W  = 4;
  // Widest vector word the helpers handle; callers cast results down to their field width.
  localparam int unsigned VEC_MAX_W = 64;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWait,
    StCheck,
    StDone
  } tv_state_e;

  function automatic logic [VEC_MAX_W-1:0] vec_inputs(input logic [VEC_MAX_W-1:0] word,
                                                       input int unsigned out_w);
    return word >> out_w;
  endfunction

  function automatic logic [VEC_MAX_W-1:0] vec_expected(input logic [VEC_MAX_W-1:0] word,
                                                         input int unsigned out_w);
    return word & ~({VEC_MAX_W{1'b1}} << out_w);
  endfunction

endpackage

// File: rtl/tv_checker.sv
// Response checker: compares the DUT output with the expected field during CHECK, keeps a
// saturating mismatch count, captures the first failing vector index and strobes err_pulse.
module tv_checker
  import tv_pkg::*;
#(
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              check_i,
  input  logic [OUT_W-1:0]  dut_out_i,
  input  logic [OUT_W-1:0]  exp_i,
  input  logic [ADDR_W-1:0] vec_idx_i,
  output logic              mismatch_o,
  output logic              err_pulse_o,
  output logic [ERR_W-1:0]  errors_o,
  output logic [ADDR_W-1:0] first_fail_o
);

  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  errors_q, errors_d;
  logic [ADDR_W-1:0] first_fail_q, first_fail_d;

  assign mismatch_o = check_i && (dut_out_i != exp_i);

  always_comb begin
    err_pulse_d  = 1'b0;
    errors_d     = errors_q;
    first_fail_d = first_fail_q;
    if (clear_i) begin
      errors_d     = '0;
      first_fail_d = '0;
    end else if (mismatch_o) begin
      err_pulse_d = 1'b1;
      if (errors_q != '1) errors_d = errors_q + ERR_W'(1);
      if (errors_q == '0) first_fail_d = vec_idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse_q  <= 1'b0;
      errors_q     <= '0;
      first_fail_q <= '0;
    end else begin
      err_pulse_q  <= err_pulse_d;
      errors_q     <= errors_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign err_pulse_o  = err_pulse_q;
  assign errors_o     = errors_q;
  assign first_fail_o = first_fail_q;

endmodule

// File: rtl/tv_sequencer.sv
// Test-vector sequencer: fetches {inputs, expected} words, drives the DUT, waits SETTLE cycles
// and hands the response to tv_checker. Each vector costs FETCH + LOAD + SETTLE + CHECK cycles.
module tv_sequencer
  import tv_pkg::*;
#(
  parameter int unsigned IN_W        = 3,
  parameter int unsigned OUT_W       = 1,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned SETTLE      = 1,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_vectors,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd_en,
  input  logic [IN_W+OUT_W-1:0] mem_rdata,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  err_pulse,
  output logic [ERR_W-1:0]      errors,
  output logic [ADDR_W:0]       vec_count,
  output logic [ADDR_W-1:0]     first_fail
);

  localparam int unsigned CW = ADDR_W + 1;

  tv_state_e         state_q, state_d;
  logic [CW-1:0]     num_q, num_d;
  logic [CW-1:0]     vec_count_q, vec_count_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic [OUT_W-1:0]  exp_q, exp_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic              start_ok;
  logic              mismatch;
  logic              last_vec;

  // Restart is allowed straight from DONE; a start while busy is dropped.
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_vec = (vec_count_q + CW'(1)) == num_q;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    vec_count_d = vec_count_q;
    dut_in_d    = dut_in_q;
    exp_d       = exp_q;
    settle_d    = settle_q;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          num_d       = num_vectors;
          vec_count_d = '0;
          state_d     = (num_vectors == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        mem_rd_en = 1'b1;
        mem_addr  = vec_count_q[ADDR_W-1:0];
        state_d   = StLoad;
      end
      StLoad: begin
        dut_in_d = IN_W'(vec_inputs(VEC_MAX_W'(mem_rdata), OUT_W));
        exp_d    = OUT_W'(vec_expected(VEC_MAX_W'(mem_rdata), OUT_W));
        settle_d = SETTLE_W'(SETTLE);
        state_d  = StWait;
      end
      StWait: begin
        settle_d = settle_q - SETTLE_W'(1);
        if (settle_q <= SETTLE_W'(1)) state_d = StCheck;
      end
      StCheck: begin
        vec_count_d = vec_count_q + CW'(1);
        if (last_vec || (STOP_ON_ERR && mismatch)) state_d = StDone;
        else state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      num_q       <= '0;
      vec_count_q <= '0;
      dut_in_q    <= '0;
      exp_q       <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      vec_count_q <= vec_count_d;
      dut_in_q    <= dut_in_d;
      exp_q       <= exp_d;
      settle_q    <= settle_d;
    end
  end

  tv_checker #(
    .OUT_W (OUT_W),
    .ADDR_W(ADDR_W)
  ) u_checker (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (start_ok),
    .check_i     (state_q == StCheck),
    .dut_out_i   (dut_out),
    .exp_i       (exp_q),
    .vec_idx_i   (vec_count_q[ADDR_W-1:0]),
    .mismatch_o  (mismatch),
    .err_pulse_o (err_pulse),
    .errors_o    (errors),
    .first_fail_o(first_fail)
  );

  assign dut_in    = dut_in_q;
  assign vec_count = vec_count_q;
  assign busy      = (state_q == StFetch) || (state_q == StLoad) ||
                     (state_q == StWait) || (state_q == StCheck);
  assign done      = (state_q == StDone);
  assign pass      = done && (errors == '0);

endmodule
